// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Single-port word store with byte/half/word loads and stores.
//            Sub-word stores are done as read-modify-write; loads sign-extend.
// Options  : define MEM_ACCESS_MISALIGN_CHK_EN to reject misaligned half/word
//            accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  memow_ctrl,
   input  logic [1:0]  adjsz_ctrl,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        done,
   output logic        misalign
);

   localparam int         ADDR_W  = DEPTH_LOG2 + 2;
   localparam int         DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;
   localparam logic [1:0] SZ_BYTE = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_next;
   logic                  r_we;
   logic [ADDR_W-1:0]     r_addr;
   logic [31:0]           r_wdata;
   logic [1:0]            r_size;
   logic [31:0]           r_word;
   logic [31:0]           r_rdata;
   logic                  r_misalign;
   logic [31:0]           r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [31:0]           w_rd_word;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [31:0]           w_load;
   logic [31:0]           w_merged;
   logic                  w_misalign;
   logic                  w_unused_addr;

   // Upper address bits alias onto the array by design.
   assign w_unused_addr = ^addr[31:ADDR_W];
   assign w_idx         = r_addr[ADDR_W-1:2];
   assign w_rd_word     = r_mem[w_idx];

`ifdef MEM_ACCESS_MISALIGN_CHK_EN
   always_comb begin
      w_misalign = 1'b0;
      case (r_size)
         SZ_BYTE: w_misalign = 1'b0;
         SZ_HALF: w_misalign = r_addr[0];
         default: w_misalign = (r_addr[1:0] != 2'b00);
      endcase
   end
`else
   assign w_misalign = 1'b0;
`endif

   assign w_byte = w_rd_word[{r_addr[1:0], 3'b000} +: 8];
   assign w_half = w_rd_word[{r_addr[1], 4'b0000} +: 16];

   always_comb begin
      w_load = w_rd_word;
      case (r_size)
         SZ_BYTE: w_load = {{24{w_byte[7]}}, w_byte};
         SZ_HALF: w_load = {{16{w_half[15]}}, w_half};
         default: w_load = w_rd_word;
      endcase
   end

   always_comb begin
      w_merged = r_word;
      case (r_size)
         SZ_BYTE: w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
         SZ_HALF: w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
         default: w_merged = r_wdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = req ? S_READ : S_IDLE;
         S_READ:  w_next = r_we ? S_WRITE : S_RESP;
         S_WRITE: w_next = S_RESP;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      ready = (r_state == S_IDLE);
      done  = (r_state == S_RESP);
   end

   assign rdata    = r_rdata;
   assign misalign = r_misalign;

   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && req) begin
         r_we    <= we;
         r_addr  <= addr[ADDR_W-1:0];
         r_wdata <= wdata;
         r_size  <= we ? memow_ctrl : adjsz_ctrl;
      end
      if (r_state == S_READ) begin
         r_word <= w_rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata    <= '0;
         r_misalign <= 1'b0;
      end else if (r_state == S_READ) begin
         r_misalign <= w_misalign;
         if (w_misalign) begin
            r_rdata <= '0;
         end else if (!r_we) begin
            r_rdata <= w_load;
         end
      end
   end

   // Reset wins over a pending write so an interrupted store leaves storage intact.
   always_ff @(posedge clk) begin
      if (!rst && r_state == S_WRITE && !w_misalign) begin
         r_mem[w_idx] <= w_merged;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Scoreboard bench for mem_access_unit against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [1:0]  memow_ctrl = '0;
   logic [1:0]  adjsz_ctrl = '0;
   logic        ready;
   logic [31:0] rdata;
   logic        done;
   logic        misalign;

   mem_access_unit #(.DEPTH_LOG2(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .memow_ctrl (memow_ctrl),
      .adjsz_ctrl (adjsz_ctrl),
      .ready      (ready),
      .rdata      (rdata),
      .done       (done),
      .misalign   (misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          st;
      logic [31:0] rd;
      bit          mis;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        q[$];
   logic [7:0]  mem_b [1024];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: 1 KiB little-endian byte memory, address taken modulo its size.
   task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, output exp_t e);
      int          nb;
      int          base;
      logic [31:0] v;
      nb   = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
      base = int'(a % 32'd1024);
      e.st = w;
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
      e.mis = (base % nb) != 0;
`else
      e.mis = 1'b0;
`endif
      base = base - (base % nb);
      e.rd = '0;
      if (!e.mis) begin
         if (w) begin
            for (int b = 0; b < nb; b++) mem_b[base + b] = d[8*b +: 8];
         end else begin
            v = '0;
            for (int b = 0; b < nb; b++) v[8*b +: 8] = mem_b[base + b];
            if (v[8*nb - 1]) for (int b = nb; b < 4; b++) v[8*b +: 8] = 8'hFF;
            e.rd = v;
         end
      end
      e.lat = w ? 3 : 2;
      e.acc = 0;
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!ready) check("ready_timeout", {31'd0, ready}, 32'd1);
   endtask

   // Issue one access at a negedge; optional noise pulses req while busy.
   task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input bit noise);
      exp_t e;
      int   t = 0;
      wait_ready();
      model(w, a, d, sz, e);
      e.acc = cyc;
      q.push_back(e);
      req = 1'b1; we = w; addr = a; wdata = d;
      memow_ctrl = sz; adjsz_ctrl = sz;
      @(negedge clk);
      req = 1'b0;
      while (!ready && t < 20) begin
         if (noise) begin
            check("busy_not_ready", {31'd0, ready}, 32'd0);
            req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
            addr = $urandom; wdata = $urandom;
         end
         @(negedge clk);
         t++;
      end
      req = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (q.size() == 0) begin
            check("unexpected_done", {31'd0, done}, 32'd0);
         end else begin
            e = q.pop_front();
            check("latency", cyc - e.acc, e.lat);
            check("misalign", {31'd0, misalign}, {31'd0, e.mis});
            if (!e.st || e.mis) check("rdata", rdata, e.rd);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_misalign", {31'd0, misalign}, 32'd0);

      for (int i = 0; i < 256; i++) issue(1'b1, 32'(i * 4), $urandom, 2'd0, 1'b0);

      issue(1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0);
      issue(1'b0, 32'h10, 32'h0, 2'd0, 1'b0);
      wait_ready();
      check("word_load", rdata, 32'hDEADBEEF);

      issue(1'b1, 32'h20, 32'h11223344, 2'd0, 1'b0);
      issue(1'b1, 32'h22, 32'h000000AB, 2'd1, 1'b0);
      issue(1'b0, 32'h20, 32'h0, 2'd3, 1'b0);
      wait_ready();
      check("byte_merge", rdata, 32'h11AB3344);

      issue(1'b1, 32'h30, 32'h0000F080, 2'd0, 1'b0);
      issue(1'b0, 32'h30, 32'h0, 2'd1, 1'b0);
      wait_ready();
      check("sext_byte0", rdata, 32'hFFFFFF80);
      issue(1'b0, 32'h30, 32'h0, 2'd2, 1'b0);
      wait_ready();
      check("sext_half0", rdata, 32'hFFFFF080);
      issue(1'b0, 32'h31, 32'h0, 2'd1, 1'b0);
      wait_ready();
      check("sext_byte1", rdata, 32'hFFFFFFF0);

      issue(1'b1, 32'h40, 32'hCAFEF00D, 2'd0, 1'b0);
      issue(1'b1, 32'h41, 32'h12345678, 2'd0, 1'b0);
      issue(1'b0, 32'h40, 32'h0, 2'd0, 1'b0);
      wait_ready();
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
      check("misalign_keep", rdata, 32'hCAFEF00D);
`else
      check("unaligned_word", rdata, 32'h12345678);
`endif

      // Store interrupted by reset in its WRITE cycle; not scoreboarded.
      issue(1'b1, 32'h50, 32'h0, 2'd0, 1'b0);
      wait_ready();
      req = 1'b1; we = 1'b1; addr = 32'h50; wdata = 32'h55; memow_ctrl = 2'd0;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_ready", {31'd0, ready}, 32'd1);
      check("midrst_rdata", rdata, 32'd0);
      issue(1'b0, 32'h50, 32'h0, 2'd0, 1'b0);
      wait_ready();
      check("midrst_mem", rdata, 32'h0);

      // Request coincident with reset is dropped.
      req = 1'b1; we = 1'b1; addr = 32'h60; wdata = 32'hFFFFFFFF; rst = 1'b1;
      @(negedge clk);
      req = 1'b0; rst = 1'b0;
      check("rstreq_ready", {31'd0, ready}, 32'd1);
      repeat (3) @(negedge clk);

      issue(1'b1, 32'h400, 32'hA5A55A5A, 2'd0, 1'b1);
      issue(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
      wait_ready();
      check("wrap_load", rdata, 32'hA5A55A5A);

      for (int i = 0; i < 200; i++)
         issue(1'($urandom_range(0, 1)), $urandom, $urandom,
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

      begin
         int t = 0;
         while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      check("queue_drained", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
